// File: rtl/conv_fir_mac_pkg.sv
// Shared types and constants for the conv_fir_mac streaming FIR block.
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    // Power-up coefficients make the filter a first difference: y = x[0] - x[1].
    localparam int DEF_COEF0 = 1;
    localparam int DEF_COEF1 = -1;

    function automatic int acc_w(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps);
    endfunction

endpackage

// File: rtl/conv_fir_mac_if.sv
// Sample, result, coefficient and status signals of conv_fir_mac bundled as one interface.
interface conv_fir_mac_if #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 8,
    parameter int ACC_W  = conv_pkg::acc_w(DATA_W, COEF_W, TAPS)
);
    import conv_pkg::*;

    // Handshakes: a transfer happens on a rising clk edge where valid && ready;
    // valid never waits on ready, and an offered result stays stable until taken.
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [ACC_W-1:0]  out_data;
    logic                     coef_we;
    logic [$clog2(TAPS)-1:0]  coef_addr;
    logic signed [COEF_W-1:0] coef_wdata;
    logic                     coef_err;
    logic                     clr;
    logic                     busy;
    state_e                   state_dbg;

    modport master (
        output in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata, clr,
        input  in_ready, out_valid, out_data, coef_err, busy, state_dbg
    );

    modport slave (
        input  in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata, clr,
        output in_ready, out_valid, out_data, coef_err, busy, state_dbg
    );

endinterface

// File: rtl/conv_mac_unit.sv
// Signed multiply-accumulate: acc += sign_extend(x * c) when enabled, cleared on request.
module conv_mac_unit #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int ACC_W  = 19
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [COEF_W-1:0] c,
    output logic signed [ACC_W-1:0]  acc_next
);
    localparam int PW = DATA_W + COEF_W;

    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] acc_q, acc_d, sum;

    always_comb begin
        prod  = x * c;
        sum   = acc_q + {{(ACC_W - PW){prod[PW-1]}}, prod};
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = sum;
        end
        acc_next = sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/conv_fir_mac.sv
// Streaming N-tap signed FIR: one accepted sample, TAPS serial MAC cycles, one held result.
module conv_fir_mac
    import conv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 8
) (
    input  logic           clk,
    input  logic           reset,
    conv_fir_mac_if.slave  bus
);
    localparam int ACC_W = acc_w(DATA_W, COEF_W, TAPS);
    localparam int AW    = $clog2(TAPS);
    localparam logic [AW-1:0] LAST_K = AW'(TAPS - 1);

    state_e                   state_q, state_d;
    logic [AW-1:0]            k_q, k_d;
    logic signed [DATA_W-1:0] x_q [TAPS];
    logic signed [DATA_W-1:0] x_d [TAPS];
    logic signed [COEF_W-1:0] coef_q [TAPS];
    logic signed [COEF_W-1:0] coef_d [TAPS];
    logic signed [ACC_W-1:0]  out_data_q, out_data_d, mac_sum;
    logic                     out_valid_q, out_valid_d;
    logic                     coef_err_q, coef_err_d;
    logic                     mac_clr, mac_en, in_ready_w, coef_ok;

    conv_mac_unit #(.DATA_W(DATA_W), .COEF_W(COEF_W), .ACC_W(ACC_W)) u_mac (
        .clk      (clk),
        .rst      (reset),
        .clr      (mac_clr),
        .en       (mac_en),
        .x        (x_q[k_q]),
        .c        (coef_q[k_q]),
        .acc_next (mac_sum)
    );

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        x_d         = x_q;
        coef_d      = coef_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        coef_err_d  = 1'b0;
        mac_clr     = 1'b0;
        mac_en      = 1'b0;
        in_ready_w  = (state_q == ST_IDLE) && !bus.clr;
        coef_ok     = in_ready_w && (32'(bus.coef_addr) < TAPS);

        // Coefficient writes land before the MAC phase, so a write that coincides
        // with a sample accept is already used by that computation.
        if (bus.coef_we) begin
            if (coef_ok) begin
                coef_d[bus.coef_addr] = bus.coef_wdata;
            end else begin
                coef_err_d = 1'b1;
            end
        end

        if (bus.clr) begin
            for (int i = 0; i < TAPS; i++) begin
                x_d[i] = '0;
            end
            mac_clr     = 1'b1;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            k_d         = '0;
            state_d     = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        for (int i = TAPS - 1; i > 0; i--) begin
                            x_d[i] = x_q[i-1];
                        end
                        x_d[0]  = bus.in_data;
                        mac_clr = 1'b1;
                        k_d     = '0;
                        state_d = ST_MAC;
                    end
                end
                ST_MAC: begin
                    mac_en = 1'b1;
                    k_d    = k_q + AW'(1);
                    if (k_q == LAST_K) begin
                        out_data_d  = mac_sum;
                        out_valid_d = 1'b1;
                        k_d         = '0;
                        state_d     = ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (bus.out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            coef_err_q  <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                x_q[i]    <= '0;
                coef_q[i] <= '0;
            end
            coef_q[0] <= COEF_W'(DEF_COEF0);
            coef_q[1] <= COEF_W'(DEF_COEF1);
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            coef_err_q  <= coef_err_d;
            x_q         <= x_d;
            coef_q      <= coef_d;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.coef_err  = coef_err_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.state_dbg = state_q;

endmodule
